// File: rtl/step02_twf_mul.sv
// Stage-2 twiddle multiplier of the 512-point streaming FFT.
// It owns the frame sample counter that addresses the twiddle ROM, and it rounds and saturates the complex product over two pipeline stages.
module step02_twf_mul #(
    parameter int N_POINT    = 512,
    parameter int DIN_WIDTH  = 13,
    parameter int TWF_WIDTH  = 9,
    parameter int TWF_FRAC   = 7,
    parameter int DOUT_WIDTH = 13
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       frame_clr,
    input  logic                       din_valid,
    input  logic [DIN_WIDTH-1:0]       din_re,
    input  logic [DIN_WIDTH-1:0]       din_im,
    output logic [$clog2(N_POINT)-1:0] twf_index,
    input  logic [TWF_WIDTH-1:0]       twf_re,
    input  logic [TWF_WIDTH-1:0]       twf_im,
    output logic                       dout_valid,
    output logic [DOUT_WIDTH-1:0]      dout_re,
    output logic [DOUT_WIDTH-1:0]      dout_im,
    output logic                       dout_sof
);

    localparam int IDX_W  = $clog2(N_POINT);
    localparam int PROD_W = DIN_WIDTH + TWF_WIDTH;
    localparam int SUM_W  = PROD_W + 1;

    localparam logic [IDX_W-1:0]        CNT_LAST = IDX_W'(N_POINT - 1);
    localparam logic signed [SUM_W-1:0] RND_ADD  = SUM_W'(2 ** (TWF_FRAC - 1));
    localparam logic signed [SUM_W-1:0] SAT_MAX  = SUM_W'(2 ** (DOUT_WIDTH - 1) - 1);
    localparam logic signed [SUM_W-1:0] SAT_MIN  = ~SAT_MAX;

    // Clip a rounded, shifted sum into the signed output range.
    function automatic logic [DOUT_WIDTH-1:0] sat_out(input logic signed [SUM_W-1:0] x);
        logic [DOUT_WIDTH-1:0] r;
        if (x > SAT_MAX) begin
            r = SAT_MAX[DOUT_WIDTH-1:0];
        end else if (x < SAT_MIN) begin
            r = SAT_MIN[DOUT_WIDTH-1:0];
        end else begin
            r = x[DOUT_WIDTH-1:0];
        end
        return r;
    endfunction

    logic [IDX_W-1:0]         cnt_r;
    logic                     v1_r;
    logic                     sof1_r;
    logic signed [PROD_W-1:0] pr0_r;
    logic signed [PROD_W-1:0] pr1_r;
    logic signed [PROD_W-1:0] pi0_r;
    logic signed [PROD_W-1:0] pi1_r;

    logic signed [PROD_W-1:0] pr0_s;
    logic signed [PROD_W-1:0] pr1_s;
    logic signed [PROD_W-1:0] pi0_s;
    logic signed [PROD_W-1:0] pi1_s;
    logic signed [SUM_W-1:0]  re_sum_s;
    logic signed [SUM_W-1:0]  im_sum_s;
    logic signed [SUM_W-1:0]  re_shift_s;
    logic signed [SUM_W-1:0]  im_shift_s;

    assign twf_index = cnt_r;

    // Frame sample counter; a clear overrides the increment, so a sample accepted alongside it keeps the old index.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r <= {IDX_W{1'b0}};
        end else if (frame_clr) begin
            cnt_r <= {IDX_W{1'b0}};
        end else if (din_valid) begin
            if (cnt_r == CNT_LAST) begin
                cnt_r <= {IDX_W{1'b0}};
            end else begin
                cnt_r <= cnt_r + IDX_W'(1);
            end
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // Full-precision partial products of sample and twiddle.
    always_comb begin
        pr0_s = $signed(din_re) * $signed(twf_re);
        pr1_s = $signed(din_im) * $signed(twf_im);
        pi0_s = $signed(din_re) * $signed(twf_im);
        pi1_s = $signed(din_im) * $signed(twf_re);
    end

    // Stage 1: capture the products together with the start-of-frame flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1_r   <= 1'b0;
            sof1_r <= 1'b0;
            pr0_r  <= {PROD_W{1'b0}};
            pr1_r  <= {PROD_W{1'b0}};
            pi0_r  <= {PROD_W{1'b0}};
            pi1_r  <= {PROD_W{1'b0}};
        end else begin
            v1_r <= din_valid;
            if (din_valid) begin
                sof1_r <= (cnt_r == {IDX_W{1'b0}});
                pr0_r  <= pr0_s;
                pr1_r  <= pr1_s;
                pi0_r  <= pi0_s;
                pi1_r  <= pi1_s;
            end else begin
                sof1_r <= sof1_r;
                pr0_r  <= pr0_r;
                pr1_r  <= pr1_r;
                pi0_r  <= pi0_r;
                pi1_r  <= pi1_r;
            end
        end
    end

    // Complex combine one bit wider than the products, then round half up and shift arithmetically.
    always_comb begin
        re_sum_s   = SUM_W'(pr0_r) - SUM_W'(pr1_r);
        im_sum_s   = SUM_W'(pi0_r) + SUM_W'(pi1_r);
        re_shift_s = (re_sum_s + RND_ADD) >>> TWF_FRAC;
        im_shift_s = (im_sum_s + RND_ADD) >>> TWF_FRAC;
    end

    // Stage 2: saturated outputs; data and sof hold while the stage is idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dout_valid <= 1'b0;
            dout_sof   <= 1'b0;
            dout_re    <= {DOUT_WIDTH{1'b0}};
            dout_im    <= {DOUT_WIDTH{1'b0}};
        end else begin
            dout_valid <= v1_r;
            if (v1_r) begin
                dout_sof <= sof1_r;
                dout_re  <= sat_out(re_shift_s);
                dout_im  <= sat_out(im_shift_s);
            end else begin
                dout_sof <= dout_sof;
                dout_re  <= dout_re;
                dout_im  <= dout_im;
            end
        end
    end

endmodule

// File: tb/tb_step02_twf_mul.sv
// Bench for step02_twf_mul: fixed vectors with constant expectations, then a randomized run driven by a modelled twiddle ROM.
// Also covers the frame clear and the mid-frame reset.
module tb_step02_twf_mul;

    logic        clk = 1'b0;
    logic        rst;
    logic        frame_clr;
    logic        din_valid;
    logic [12:0] din_re;
    logic [12:0] din_im;
    logic [8:0]  twf_index;
    logic [8:0]  twf_re;
    logic [8:0]  twf_im;
    logic        dout_valid;
    logic [12:0] dout_re;
    logic [12:0] dout_im;
    logic        dout_sof;

    always #5 clk = ~clk;

    step02_twf_mul dut (
        .clk(clk), .rst(rst), .frame_clr(frame_clr), .din_valid(din_valid),
        .din_re(din_re), .din_im(din_im), .twf_index(twf_index),
        .twf_re(twf_re), .twf_im(twf_im), .dout_valid(dout_valid),
        .dout_re(dout_re), .dout_im(dout_im), .dout_sof(dout_sof)
    );

    logic       use_rom;
    logic [8:0] drv_tre;
    logic [8:0] drv_tim;
    int         rom_re [512];
    int         rom_im [512];

    // Twiddle source: either a modelled combinational ROM or directly driven values.
    always_comb begin
        if (use_rom) begin
            twf_re = 9'(rom_re[twf_index]);
            twf_im = 9'(rom_im[twf_index]);
        end else begin
            twf_re = drv_tre;
            twf_im = drv_tim;
        end
    end

    int checks = 0;
    int errors = 0;
    int model_idx;
    int last_re, last_im;
    int sof_seen;
    logic p_v, p_sof;
    int p_re, p_im;

    typedef struct {
        int dr; int di; int tr; int ti; int er; int ei;
    } vec_t;

    function automatic int floor_div128(int a);
        int q;
        q = a / 128;
        if ((a % 128) != 0 && a < 0) q = q - 1;
        return q;
    endfunction

    function automatic int clip13(int a);
        if (a > 4095) return 4095;
        if (a < -4096) return -4096;
        return a;
    endfunction

    function automatic int ref_re(int dr, int di, int tr, int ti);
        return clip13(floor_div128(dr * tr - di * ti + 64));
    endfunction

    function automatic int ref_im(int dr, int di, int tr, int ti);
        return clip13(floor_div128(dr * ti + di * tr + 64));
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock: drive inputs at the falling edge, advance, then check the result of the sample from the previous call.
    task automatic cycle(input logic v, input logic clr, input int dr, input int di,
                         input int tr, input int ti, input int er, input int ei);
        logic c_sof;
        din_valid = v;
        frame_clr = clr;
        din_re    = 13'(dr);
        din_im    = 13'(di);
        if (!use_rom) begin
            drv_tre = 9'(tr);
            drv_tim = 9'(ti);
        end
        #1;
        check("twf_index", int'(twf_index), model_idx);
        c_sof = (model_idx == 0);
        if (clr) model_idx = 0;
        else if (v) model_idx = (model_idx + 1) % 512;
        @(posedge clk);
        @(negedge clk);
        check("dout_valid", int'(dout_valid), int'(p_v));
        if (p_v) begin
            check("dout_re", int'($signed(dout_re)), p_re);
            check("dout_im", int'($signed(dout_im)), p_im);
            check("dout_sof", int'(dout_sof), int'(p_sof));
            last_re = p_re;
            last_im = p_im;
            if (dout_sof) sof_seen++;
        end else begin
            check("hold_re", int'($signed(dout_re)), last_re);
            check("hold_im", int'($signed(dout_im)), last_im);
        end
        p_v = v; p_re = er; p_im = ei; p_sof = c_sof;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        din_valid = 1'b0;
        frame_clr = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rst_dout_valid", int'(dout_valid), 0);
        check("rst_dout_re", int'(dout_re), 0);
        check("rst_dout_im", int'(dout_im), 0);
        check("rst_dout_sof", int'(dout_sof), 0);
        check("rst_twf_index", int'(twf_index), 0);
        rst = 1'b0;
        model_idx = 0;
        p_v = 1'b0; p_sof = 1'b0; p_re = 0; p_im = 0;
        last_re = 0; last_im = 0;
    endtask

    // Random ROM-mode sample at the current modelled index.
    task automatic rand_cycle(input logic v, input logic clr);
        int dr, di, tr, ti;
        dr = int'($urandom_range(0, 8191)) - 4096;
        di = int'($urandom_range(0, 8191)) - 4096;
        tr = rom_re[model_idx];
        ti = rom_im[model_idx];
        cycle(v, clr, dr, di, tr, ti, ref_re(dr, di, tr, ti), ref_im(dr, di, tr, ti));
    endtask

    initial begin
        vec_t vecs [9];
        int   nvalid;
        logic did_clr, did_rst, v;

        vecs[0] = '{dr: 100,  di: -50,   tr: 128,  ti: 0,    er: 100,   ei: -50};
        vecs[1] = '{dr: 100,  di: 20,    tr: 0,    ti: -128, er: 20,    ei: -100};
        vecs[2] = '{dr: 1,    di: 0,     tr: 64,   ti: 0,    er: 1,     ei: 0};
        vecs[3] = '{dr: -1,   di: 0,     tr: 64,   ti: 0,    er: 0,     ei: 0};
        vecs[4] = '{dr: 3,    di: 0,     tr: -64,  ti: 0,    er: -1,    ei: 0};
        vecs[5] = '{dr: 4095, di: -4096, tr: 128,  ti: -128, er: -1,    ei: -4096};
        vecs[6] = '{dr: -4096, di: -4096, tr: 128, ti: 128,  er: 0,     ei: -4096};
        vecs[7] = '{dr: 4095, di: 4095,  tr: -256, ti: -256, er: 0,     ei: -4096};
        vecs[8] = '{dr: 4095, di: -4096, tr: 255,  ti: 255,  er: 4095,  ei: -2};

        rst = 1'b1; frame_clr = 1'b0; din_valid = 1'b0;
        din_re = 13'd0; din_im = 13'd0;
        drv_tre = 9'd0; drv_tim = 9'd0;
        use_rom = 1'b0;
        sof_seen = 0;
        for (int i = 0; i < 512; i++) begin
            rom_re[i] = int'($urandom_range(0, 511)) - 256;
            rom_im[i] = int'($urandom_range(0, 511)) - 256;
        end
        rom_re[0] = 128;  rom_im[0] = 0;
        rom_re[1] = -256; rom_im[1] = 255;
        rom_re[2] = 128;  rom_im[2] = -128;

        // Fixed vectors back to back; vector 0 lands on index 0.
        apply_reset();
        for (int i = 0; i < 9; i++)
            cycle(1'b1, 1'b0, vecs[i].dr, vecs[i].di, vecs[i].tr, vecs[i].ti, vecs[i].er, vecs[i].ei);
        for (int i = 0; i < 3; i++)
            cycle(1'b0, 1'b0, 0, 0, 0, 0, 0, 0);
        check("table_sof_count", sof_seen, 1);

        // Random run over the modelled ROM: wrap, frame clear at 200, reset at 300.
        use_rom = 1'b1;
        apply_reset();
        sof_seen = 0;
        nvalid = 0;
        did_clr = 1'b0;
        did_rst = 1'b0;
        for (int k = 0; k < 3000; k++) begin
            v = ($urandom_range(0, 9) < 7);
            if (!did_clr && nvalid > 512 && model_idx == 200) begin
                rand_cycle(1'b1, 1'b1);
                did_clr = 1'b1;
                nvalid++;
            end else if (did_clr && !did_rst && model_idx == 300) begin
                check("sof_before_rst", sof_seen, 3);
                rand_cycle(1'b1, 1'b0);
                rand_cycle(1'b1, 1'b0);
                din_valid = 1'b1;
                #2;
                apply_reset();
                for (int j = 0; j < 4; j++)
                    cycle(1'b0, 1'b0, 0, 0, 0, 0, 0, 0);
                did_rst = 1'b1;
            end else begin
                rand_cycle(v, 1'b0);
                if (v) nvalid++;
            end
        end
        for (int i = 0; i < 3; i++)
            cycle(1'b0, 1'b0, 0, 0, 0, 0, 0, 0);
        check("clr_and_rst_reached", int'(did_clr) + int'(did_rst), 2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
